spi_slave_axi_cmd_ctrl: RTL and testbench
=========================================

Name: spi_slave_axi_cmd_ctrl

Overview:
Command/framing controller in the AXI clock domain, directly upstream of the SPI-slave AXI plug. It consumes 32-bit words already deserialised and synchronised from the SPI shifter, and decodes a command word and an address word for each chip-select frame. It drives the plug's address/start/wrap controls and forwards write payload words to the plug's rx stream. Non-payload words and unknown commands are discarded, and errors are counted.

Parameters:
AXI_ADDR_WIDTH, 32, width of rxtx_addr and of the captured address word (low bits of the 32-bit word used; zero-extended if wider)
OPC_WRITE, 8'h02, opcode for a write frame
OPC_READ, 8'h0B, opcode for a read frame
OPC_WRAP, 8'h11, opcode for the set-wrap-length frame

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  reset; synchronous, active-low
cs  in  1  chip select, already synchronised; 1 = deselected (frame end)
in_data  in  32  word from SPI deserialiser
in_valid  in  1  in_data valid
in_ready  out  1  word accepted when in_valid & in_ready
rxtx_addr  out  AXI_ADDR_WIDTH  frame start address, registered
rxtx_addr_valid  out  1  one-cycle pulse: load rxtx_addr into the plug
start_tx  out  1  one-cycle pulse: start read prefetch
rx_data  out  32  write payload word to the plug
rx_valid  out  1  payload valid
rx_ready  in  1  plug accepts payload
wrap_length  out  16  wrap length in words, registered
busy  out  1  1 whenever state != IDLE
err_count  out  8  saturating count of unknown opcodes

Behaviour:
- Reset (axi_aresetn=0 at a clock edge): state=IDLE; rxtx_addr=0, rxtx_addr_valid=0, start_tx=0, wrap_length=16'h0000, err_count=0. Combinational outputs follow the IDLE state. A reset mid-frame aborts the frame and drops any partially accepted word.
- The command word is in_data[31:24] = opcode. For OPC_WRAP, in_data[15:0] = new wrap length. Other bits are ignored.
- States: IDLE, ADDR_W, ADDR_R, WDATA, RD_START, RD_ACTIVE, DISCARD.
- cs=1 has priority in every state: next state = IDLE. in_ready=0 and rx_valid=0 in that cycle. A pending rxtx_addr_valid or start_tx pulse is still deasserted the following cycle; pulses never exceed 1 cycle.
- IDLE: in_ready=1. On an accepted word, decode the opcode:
  - WRITE -> ADDR_W.
  - READ -> ADDR_R.
  - WRAP -> wrap_length <= in_data[15:0] at the same edge; -> DISCARD.
  - Other -> err_count += 1 (saturates at 8'hFF); -> DISCARD.
- ADDR_W / ADDR_R: in_ready=1. On an accepted word, rxtx_addr <= in_data and rxtx_addr_valid <= 1 (high exactly the next cycle). Next state is WDATA or RD_START respectively.
- WDATA: combinational pass-through. rx_data=in_data, rx_valid=in_valid&!cs, in_ready=rx_ready&!cs. No buffering and no word loss; back-pressure propagates in 0 cycles. Stays in WDATA until cs=1.
- RD_START: entered in the cycle rxtx_addr_valid is high. start_tx is registered and is high in the cycle after rxtx_addr_valid (addr load precedes start by exactly 1 cycle). Next state is RD_ACTIVE. in_ready=0.
- RD_ACTIVE: in_ready=1. Incoming words (SPI dummy/turnaround) are discarded. rx_valid=0. Exit only on cs=1.
- DISCARD: in_ready=1, words dropped, exit only on cs=1.
- rx_valid=0 in all states other than WDATA.
- wrap_length and err_count persist across frames; only reset clears them.
- cs=1 in the same cycle as an accepted command word: the word is not accepted (in_ready=0). err_count and wrap_length are unchanged.
- busy is combinational from state.

Test Plan:
- Write frame: cs=0; words 0x02000000, 0x1C000100, 0xDEADBEEF, 0x12345678, rx_ready=1 -> rxtx_addr=0x1C000100 with a 1-cycle rxtx_addr_valid. rx_valid carries 0xDEADBEEF then 0x12345678. start_tx never pulses.
- Write back-pressure: in the same frame, hold rx_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 for those 5 cycles. The word is delivered once when rx_ready=1; no duplicates, no drops.
- Read frame: words 0x0B000000, 0x00001000, then 3 dummy words, cs rises -> rxtx_addr_valid in cycle N, start_tx in cycle N+1. The dummies are consumed with rx_valid=0. After cs rises, state=IDLE and busy=0.
- Wrap + persistence: frame 0x11000008, then cs toggle -> wrap_length=8. A following read frame leaves wrap_length=8. A reset mid-frame -> wrap_length=0, all pulses 0.
- Errors: 300 frames each starting with 0x55000000 -> err_count saturates at 0xFF. Words after the bad opcode are discarded (rx_valid stays 0).
- Abort: cs=1 in ADDR_W on the cycle the address word arrives -> no rxtx_addr_valid, in_ready=0 that cycle, next state=IDLE.

Source files
------------

// File: rtl/spi_slave_axi_cmd_ctrl.sv
// Command/framing controller for the SPI-slave AXI plug: decodes a command and an address word
// per chip-select frame, drives the plug's address/start/wrap controls and forwards write payload.
module spi_slave_axi_cmd_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter logic [7:0]  OPC_WRITE      = 8'h02,
    parameter logic [7:0]  OPC_READ       = 8'h0B,
    parameter logic [7:0]  OPC_WRAP       = 8'h11
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      cs,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [AXI_ADDR_WIDTH-1:0] rxtx_addr,
    output logic                      rxtx_addr_valid,
    output logic                      start_tx,
    output logic [31:0]               rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [15:0]               wrap_length,
    output logic                      busy,
    output logic [7:0]                err_count
);

    typedef enum logic [2:0] {
        StIdle,
        StAddrW,
        StAddrR,
        StWdata,
        StRdStart,
        StRdActive,
        StDiscard
    } state_e;

    state_e                    state_q;
    logic                      accept;
    logic [7:0]                opcode;
    logic [AXI_ADDR_WIDTH-1:0] addr_word;

    assign opcode = in_data[31:24];
    assign accept = in_valid & in_ready;

    if (AXI_ADDR_WIDTH >= 32) begin : g_addr_ext
        assign addr_word = AXI_ADDR_WIDTH'(in_data);
    end else begin : g_addr_trunc
        assign addr_word = in_data[AXI_ADDR_WIDTH-1:0];
    end

    // Payload is a zero-latency pass-through so back-pressure reaches the SPI side immediately.
    always_comb begin
        in_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = in_data;
        busy     = (state_q != StIdle);
        if (!cs) begin
            case (state_q)
                StIdle, StAddrW, StAddrR, StRdActive, StDiscard: in_ready = 1'b1;
                StWdata: begin
                    in_ready = rx_ready;
                    rx_valid = in_valid;
                end
                default: in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q         <= StIdle;
            rxtx_addr       <= '0;
            rxtx_addr_valid <= 1'b0;
            start_tx        <= 1'b0;
            wrap_length     <= 16'h0000;
            err_count       <= 8'h00;
        end else begin
            rxtx_addr_valid <= 1'b0;
            start_tx        <= 1'b0;
            if (cs) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (accept) begin
                            if (opcode == OPC_WRITE) begin
                                state_q <= StAddrW;
                            end else if (opcode == OPC_READ) begin
                                state_q <= StAddrR;
                            end else if (opcode == OPC_WRAP) begin
                                wrap_length <= in_data[15:0];
                                state_q     <= StDiscard;
                            end else begin
                                if (err_count != 8'hFF) begin
                                    err_count <= err_count + 8'd1;
                                end
                                state_q <= StDiscard;
                            end
                        end
                    end
                    StAddrW: begin
                        if (accept) begin
                            rxtx_addr       <= addr_word;
                            rxtx_addr_valid <= 1'b1;
                            state_q         <= StWdata;
                        end
                    end
                    StAddrR: begin
                        if (accept) begin
                            rxtx_addr       <= addr_word;
                            rxtx_addr_valid <= 1'b1;
                            state_q         <= StRdStart;
                        end
                    end
                    // Address load precedes the prefetch start by exactly one cycle.
                    StRdStart: begin
                        start_tx <= 1'b1;
                        state_q  <= StRdActive;
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_axi_cmd_ctrl.sv
// Self-checking bench: directed vector table, hand sequences and random frames against a
// frame-level reference model (words accepted per frame, opcode, pulse bookkeeping).
module tb_spi_slave_axi_cmd_ctrl;

    localparam logic [7:0] OW = 8'h02;
    localparam logic [7:0] OR = 8'h0B;
    localparam logic [7:0] OX = 8'h11;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cs;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rxtx_addr;
    logic        rxtx_addr_valid;
    logic        start_tx;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] wrap_length;
    logic        busy;
    logic [7:0]  err_count;

    spi_slave_axi_cmd_ctrl dut (
        .axi_aclk       (clk),
        .axi_aresetn    (rstn),
        .cs             (cs),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .rxtx_addr      (rxtx_addr),
        .rxtx_addr_valid(rxtx_addr_valid),
        .start_tx       (start_tx),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .wrap_length    (wrap_length),
        .busy           (busy),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position and decoded opcode, not the RTL state machine.
    int          m_n;
    logic [7:0]  m_opc;
    logic [31:0] m_addr;
    logic [15:0] m_wrap;
    logic [7:0]  m_err;
    logic        m_av;
    logic        m_st;
    logic        m_ready;

    logic        s_ir, s_rxv, s_av, s_st, s_busy;
    logic [31:0] s_addr;
    logic [31:0] got_q[$];

    function automatic logic model_ready();
        if (cs) return 1'b0;
        if (m_n == 0) return 1'b1;
        if (m_opc == OW) return (m_n == 1) ? 1'b1 : rx_ready;
        if (m_opc == OR && m_n == 2 && m_av) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_n = 0; m_opc = 8'h00; m_addr = '0; m_wrap = '0; m_err = '0;
        m_av = 1'b0; m_st = 1'b0;
    endtask

    task automatic model_update();
        logic nav, nst, acc;
        nav = 1'b0;
        nst = 1'b0;
        acc = in_valid && m_ready;
        if (cs) begin
            m_n = 0;
        end else begin
            if (m_opc == OR && m_n == 2 && m_av) nst = 1'b1;
            if (acc) begin
                if (m_n == 0) begin
                    m_opc = in_data[31:24];
                    if (m_opc == OX) m_wrap = in_data[15:0];
                    else if (m_opc != OW && m_opc != OR && m_err != 8'hFF) m_err = m_err + 8'd1;
                end else if (m_n == 1 && (m_opc == OW || m_opc == OR)) begin
                    m_addr = in_data;
                    nav = 1'b1;
                end
                if (m_n < 1000) m_n++;
            end
        end
        m_av = nav;
        m_st = nst;
    endtask

    // One clock: sample and check at the falling edge, advance model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_ir = in_ready; s_rxv = rx_valid; s_av = rxtx_addr_valid; s_st = start_tx;
        s_busy = busy; s_addr = rxtx_addr;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        m_ready = model_ready();
        if (rstn) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
            chk("rx_valid", {31'b0, rx_valid},
                {31'b0, !cs && m_opc == OW && m_n >= 2 && in_valid});
            if (rx_valid) chk("rx_data", rx_data, in_data);
            chk("addr_valid", {31'b0, rxtx_addr_valid}, {31'b0, m_av});
            chk("start_tx", {31'b0, start_tx}, {31'b0, m_st});
            chk("busy", {31'b0, busy}, {31'b0, m_n != 0});
            chk("rxtx_addr", rxtx_addr, m_addr);
            chk("wrap_length", {16'b0, wrap_length}, {16'b0, m_wrap});
            chk("err_count", {24'b0, err_count}, {24'b0, m_err});
        end
        @(posedge clk);
        if (!rstn) model_reset();
        else model_update();
        #1;
    endtask

    task automatic drive(input logic c, input logic v, input logic [31:0] d, input logic rr);
        cs = c; in_valid = v; in_data = d; rx_ready = rr;
        cycle();
    endtask

    typedef struct {
        logic        cs;
        logic        iv;
        logic [31:0] d;
        logic        rr;
        logic        e_ir;
        logic        e_rxv;
        logic        e_av;
        logic        e_st;
        logic        e_busy;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vt[20];

    initial begin
        logic [7:0] pick;
        int         len;

        // Write frame with 5 cycles of back-pressure, then a read frame with 3 dummies.
        vt[0]  = '{1'b0, 1'b1, 32'h0200_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 32'h1C00_0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vt[2]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1C00_0100};
        for (int i = 3; i < 8; i++)
            vt[i] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1C00_0100};
        vt[8]  = '{1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1C00_0100};
        vt[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1C00_0100};
        vt[10] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1C00_0100};
        vt[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C00_0100};
        vt[12] = '{1'b0, 1'b1, 32'h0B00_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C00_0100};
        vt[13] = '{1'b0, 1'b1, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1C00_0100};
        vt[14] = '{1'b0, 1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_1000};
        vt[15] = '{1'b0, 1'b1, 32'hAAAA_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1000};
        vt[16] = '{1'b0, 1'b1, 32'hAAAA_0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000};
        vt[17] = '{1'b0, 1'b1, 32'hAAAA_0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000};
        vt[18] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000};
        vt[19] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000};

        model_reset();
        rstn = 1'b0; cs = 1'b1; in_valid = 1'b0; in_data = '0; rx_ready = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
        #1;
        chk("reset_addr", rxtx_addr, 32'h0);
        chk("reset_wrap", {16'b0, wrap_length}, 32'h0);
        chk("reset_err", {24'b0, err_count}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);

        got_q.delete();
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].cs, vt[i].iv, vt[i].d, vt[i].rr);
            chk($sformatf("vec%0d_in_ready", i), {31'b0, s_ir}, {31'b0, vt[i].e_ir});
            chk($sformatf("vec%0d_rx_valid", i), {31'b0, s_rxv}, {31'b0, vt[i].e_rxv});
            chk($sformatf("vec%0d_addr_valid", i), {31'b0, s_av}, {31'b0, vt[i].e_av});
            chk($sformatf("vec%0d_start_tx", i), {31'b0, s_st}, {31'b0, vt[i].e_st});
            chk($sformatf("vec%0d_busy", i), {31'b0, s_busy}, {31'b0, vt[i].e_busy});
            chk($sformatf("vec%0d_addr", i), s_addr, vt[i].e_addr);
        end
        chk("payload_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            chk("payload0", got_q[0], 32'hDEAD_BEEF);
            chk("payload1", got_q[1], 32'h1234_5678);
        end

        // Wrap length set, then persists through a read frame.
        drive(1'b0, 1'b1, 32'h1100_0008, 1'b1);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap_set", {16'b0, wrap_length}, 32'd8);
        drive(1'b0, 1'b1, 32'h0B00_0000, 1'b1);
        drive(1'b0, 1'b1, 32'h0000_2000, 1'b1);
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk("wrap_persist", {16'b0, wrap_length}, 32'd8);

        // Reset in the middle of a write frame, right as the address pulse is pending.
        drive(1'b0, 1'b1, 32'h0200_0000, 1'b1);
        drive(1'b0, 1'b1, 32'h3000_0000, 1'b1);
        rstn = 1'b0;
        drive(1'b0, 1'b1, 32'h5555_5555, 1'b1);
        rstn = 1'b1;
        chk("midrst_wrap", {16'b0, wrap_length}, 32'h0);
        chk("midrst_av", {31'b0, rxtx_addr_valid}, 32'h0);
        chk("midrst_st", {31'b0, start_tx}, 32'h0);
        chk("midrst_addr", rxtx_addr, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);

        // Unknown opcode frames saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 32'h5500_0000, 1'b1);
            drive(1'b0, 1'b1, 32'h0200_0000, 1'b1);
            chk("bad_rx_valid", {31'b0, s_rxv}, 32'h0);
            drive(1'b1, 1'b0, 32'h0, 1'b1);
        end
        chk("err_sat", {24'b0, err_count}, 32'hFF);

        // cs rises exactly as the address word arrives.
        drive(1'b0, 1'b1, 32'h0200_0000, 1'b1);
        drive(1'b1, 1'b1, 32'h4000_0000, 1'b1);
        chk("abort_in_ready", {31'b0, s_ir}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("abort_av", {31'b0, s_av}, 32'h0);
        chk("abort_busy", {31'b0, s_busy}, 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b1);

        // Random frames against the model, with occasional resets.
        for (int f = 0; f < 400; f++) begin
            case ($urandom_range(0, 4))
                0: pick = OW;
                1: pick = OR;
                2: pick = OX;
                default: pick = 8'($urandom);
            endcase
            len = $urandom_range(1, 10);
            for (int c = 0; c < len; c++) begin
                logic [31:0] d;
                d = $urandom;
                if (m_n == 0) d[31:24] = pick;
                rstn = ($urandom_range(0, 299) != 0);
                drive(1'b0, ($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0));
                rstn = 1'b1;
            end
            for (int c = 0; c < int'($urandom_range(1, 2)); c++)
                drive(1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
